// File: rtl/lc3b_mc_alu_if.sv
// Request/response bus of the multicycle LC-3b ALU.
// Handshake: a transfer happens on a rising clk edge where valid && ready; senders hold payload stable while valid && !ready.
interface lc3b_mc_alu_if #(
   parameter int WIDTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       aluop;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] result;
   logic             illegal;
   logic             busy;
   logic [1:0]       state_dbg;

   modport master (
      output req_valid, aluop, a, b, resp_ready,
      input  req_ready, resp_valid, result, illegal, busy, state_dbg
   );

   modport slave (
      input  req_valid, aluop, a, b, resp_ready,
      output req_ready, resp_valid, result, illegal, busy, state_dbg
   );
endinterface

// File: rtl/lc3b_mc_alu.sv
// Multicycle ALU: single-cycle logic/arith ops, bit-serial shifts and a shift-add multiplier.
// Operands are captured on accept; the result register doubles as the shift/accumulate register.
module lc3b_mc_alu #(
   parameter int WIDTH   = 16,
   parameter int SHIFT_W = $clog2(WIDTH)
) (
   input logic               clk,
   input logic               reset,
   lc3b_mc_alu_if.slave      bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_NOT  = 4'd2;
   localparam logic [3:0] OP_PASS = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SRL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd6;
   localparam logic [3:0] OP_SUB  = 4'd7;
   localparam logic [3:0] OP_XOR  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       op_code;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] result_q;
   logic             illegal_q;
   logic [SHIFT_W-1:0] shamt;

   assign shamt = bus.b[SHIFT_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         op_code   <= '0;
         op_a      <= '0;
         op_b      <= '0;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_code   <= bus.aluop;
                  op_a      <= bus.a;
                  op_b      <= bus.b;
                  illegal_q <= 1'b0;
                  state     <= DONE;
                  case (bus.aluop)
                     OP_ADD:  result_q <= bus.a + bus.b;
                     OP_AND:  result_q <= bus.a & bus.b;
                     OP_NOT:  result_q <= ~bus.a;
                     OP_PASS: result_q <= bus.a;
                     OP_SUB:  result_q <= bus.a - bus.b;
                     OP_XOR:  result_q <= bus.a ^ bus.b;
                     OP_SLL, OP_SRL, OP_SRA: begin
                        // A zero amount skips EXEC entirely.
                        result_q <= bus.a;
                        if (shamt != '0) begin
                           cnt   <= CNT_W'(shamt);
                           state <= EXEC;
                        end
                     end
                     OP_MUL: begin
                        result_q <= '0;
                        cnt      <= CNT_W'(WIDTH);
                        state    <= EXEC;
                     end
                     default: begin
                        result_q  <= '0;
                        illegal_q <= 1'b1;
                     end
                  endcase
               end
            end
            EXEC: begin
               case (op_code)
                  OP_SLL: result_q <= {result_q[WIDTH-2:0], 1'b0};
                  OP_SRL: result_q <= {1'b0, result_q[WIDTH-1:1]};
                  OP_SRA: result_q <= {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                  OP_MUL: begin
                     if (op_b[0]) result_q <= result_q + op_a;
                     op_a <= {op_a[WIDTH-2:0], 1'b0};
                     op_b <= {1'b0, op_b[WIDTH-1:1]};
                  end
                  default: result_q <= result_q;
               endcase
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               if (cnt <= CNT_W'(1)) state <= DONE;
            end
            DONE: begin
               if (bus.resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == DONE);
   assign bus.busy       = (state != IDLE);
   assign bus.result     = result_q;
   assign bus.illegal    = illegal_q;
   assign bus.state_dbg  = state;
endmodule

// File: tb/tb_lc3b_mc_alu.sv
// Directed bench for lc3b_mc_alu: hand-computed vectors, latency, stall, reset-abort and illegal-op cases.
module tb_lc3b_mc_alu;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

   lc3b_mc_alu_if #(.WIDTH(16)) bus ();

   lc3b_mc_alu #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op, check busy/no-response for lat-1 cycles, then the response and the return to IDLE.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] av,
                         input logic [15:0] bv, input int lat, input logic [15:0] exp_res,
                         input logic exp_ill);
      bus.req_valid = 1'b1;
      bus.aluop     = op;
      bus.a         = av;
      bus.b         = bv;
      check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 1'b0;
      bus.a         = 16'($urandom_range(0, 65535));
      bus.b         = 16'($urandom_range(0, 65535));
      bus.aluop     = 4'($urandom_range(0, 15));
      for (int c = 1; c < lat; c++) begin
         check({tag, ".early_valid"}, 32'(bus.resp_valid), 32'd0);
         check({tag, ".busy"}, 32'(bus.busy), 32'd1);
         step();
      end
      check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, ".result"}, 32'(bus.result), 32'(exp_res));
      check({tag, ".illegal"}, 32'(bus.illegal), 32'(exp_ill));
      step();
      check({tag, ".idle_after"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      n_cmp          = 0;
      n_fail         = 0;
      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.aluop      = 4'd0;
      bus.a          = 16'd0;
      bus.b          = 16'd0;
      bus.resp_ready = 1'b1;
      step();
      step();
      reset = 1'b0;

      check("rst.req_ready",  32'(bus.req_ready),  32'd1);
      check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst.result",     32'(bus.result),     32'd0);
      check("rst.illegal",    32'(bus.illegal),    32'd0);
      check("rst.busy",       32'(bus.busy),       32'd0);
      check("rst.state",      32'(bus.state_dbg),  32'd0);

      run_op("add",      4'd0, 16'h7FFF, 16'h0001, 1,  16'h8000, 1'b0);
      run_op("and",      4'd1, 16'hF0F0, 16'h3C3C, 1,  16'h3030, 1'b0);
      run_op("not",      4'd2, 16'h1234, 16'hAAAA, 1,  16'hEDCB, 1'b0);
      run_op("pass",     4'd3, 16'hBEEF, 16'h5555, 1,  16'hBEEF, 1'b0);
      run_op("sub",      4'd7, 16'h0000, 16'h0001, 1,  16'hFFFF, 1'b0);
      run_op("xor",      4'd8, 16'h00FF, 16'h0F0F, 1,  16'h0FF0, 1'b0);
      run_op("sra3",     4'd6, 16'h8000, 16'h0003, 4,  16'hF000, 1'b0);
      run_op("sra_pos",  4'd6, 16'h4000, 16'h0002, 3,  16'h1000, 1'b0);
      run_op("sll0",     4'd4, 16'h1234, 16'h0000, 1,  16'h1234, 1'b0);
      run_op("sll4",     4'd4, 16'h0001, 16'h00F4, 5,  16'h0010, 1'b0);
      run_op("srl15",    4'd5, 16'h8000, 16'h000F, 16, 16'h0001, 1'b0);
      run_op("mul_a",    4'd9, 16'h0123, 16'h0010, 17, 16'h1230, 1'b0);
      run_op("mul_ff",   4'd9, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 1'b0);
      run_op("mul_b",    4'd9, 16'h00FF, 16'h0101, 17, 16'hFFFF, 1'b0);
      run_op("ill_f",    4'hF, 16'h1111, 16'h2222, 1,  16'h0000, 1'b1);
      run_op("ill_a",    4'hA, 16'hFFFF, 16'hFFFF, 1,  16'h0000, 1'b1);
      run_op("xor_post", 4'd8, 16'h00FF, 16'h0F0F, 1,  16'h0FF0, 1'b0);

      // Consumer stalls in DONE while a new request and changing operands are presented.
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.aluop      = 4'd0;
      bus.a          = 16'h0003;
      bus.b          = 16'h0004;
      step();
      for (int c = 0; c < 5; c++) begin
         bus.a = 16'($urandom_range(0, 65535));
         bus.b = 16'($urandom_range(0, 65535));
         check("stall.resp_valid", 32'(bus.resp_valid), 32'd1);
         check("stall.result",     32'(bus.result),     32'h0007);
         check("stall.req_ready",  32'(bus.req_ready),  32'd0);
         step();
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      step();
      check("stall.release_ready", 32'(bus.req_ready),  32'd1);
      check("stall.release_rv",    32'(bus.resp_valid), 32'd0);
      step();
      check("stall.no_queue_busy", 32'(bus.busy),       32'd0);
      check("stall.no_queue_rv",   32'(bus.resp_valid), 32'd0);

      // Reset during cycle 8 of a multiply aborts it.
      bus.req_valid = 1'b1;
      bus.aluop     = 4'd9;
      bus.a         = 16'h0123;
      bus.b         = 16'h0010;
      step();
      bus.req_valid = 1'b0;
      for (int c = 1; c < 8; c++) step();
      check("abort.busy_before", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort.resp_valid", 32'(bus.resp_valid), 32'd0);
      check("abort.busy",       32'(bus.busy),       32'd0);
      check("abort.req_ready",  32'(bus.req_ready),  32'd1);
      check("abort.result",     32'(bus.result),     32'd0);
      for (int c = 0; c < 20; c++) begin
         check("abort.no_resp", 32'(bus.resp_valid), 32'd0);
         step();
      end

      // Reset wins over a simultaneous request.
      bus.req_valid = 1'b1;
      bus.aluop     = 4'd0;
      bus.a         = 16'h0001;
      bus.b         = 16'h0001;
      reset         = 1'b1;
      step();
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      check("rst_prio.busy",      32'(bus.busy),       32'd0);
      check("rst_prio.resp_valid", 32'(bus.resp_valid), 32'd0);
      step();
      check("rst_prio.still_idle", 32'(bus.req_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
